// File: rtl/ahb_decoder.sv
// AHB-Lite address decoder with data-phase select register, HREADY/HRESP
// response mux and a default slave that answers unmapped transfers with ERROR.

module ahb_decoder_region #(
  parameter logic [31:0] BASE = 32'h0,
  parameter logic [31:0] MASK = 32'h0
) (
  input  logic [31:0] haddr,
  output logic        hit
);
  assign hit = ((haddr & MASK) == BASE);
endmodule

module ahb_decoder #(
  parameter logic [31:0] BASE0 = 32'h0000_0000,
  parameter logic [31:0] MASK0 = 32'hFFFF_0000,
  parameter logic [31:0] BASE1 = 32'h2000_0000,
  parameter logic [31:0] MASK1 = 32'hFFFF_0000,
  parameter logic [31:0] BASE2 = 32'h4000_0000,
  parameter logic [31:0] MASK2 = 32'hFFFF_F000,
  parameter logic [31:0] BASE3 = 32'h4000_1000,
  parameter logic [31:0] MASK3 = 32'hFFFF_F000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HREADYOUT0,
  input  logic        HREADYOUT1,
  input  logic        HREADYOUT2,
  input  logic        HREADYOUT3,
  input  logic        HRESP0,
  input  logic        HRESP1,
  input  logic        HRESP2,
  input  logic        HRESP3,
  output logic [3:0]  HSEL,
  output logic [3:0]  HSEL_D,
  output logic        HREADY,
  output logic        HRESP
);
  localparam int NUM_SLV = 4;
  localparam logic [NUM_SLV-1:0][31:0] BASES = {BASE3, BASE2, BASE1, BASE0};
  localparam logic [NUM_SLV-1:0][31:0] MASKS = {MASK3, MASK2, MASK1, MASK0};

  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_e;

  logic [NUM_SLV-1:0] hit;
  logic [NUM_SLV-1:0] hro, hrs;
  logic [NUM_SLV-1:0] sel_d_q, sel_d_d;
  logic               def_d_q, def_d_d;
  ds_state_e          ds_q, ds_d;
  logic               act, unmapped_act;
  logic               ds_rdy, ds_resp;

  for (genvar i = 0; i < NUM_SLV; i++) begin : g_rgn
    ahb_decoder_region #(.BASE(BASES[i]), .MASK(MASKS[i])) u_rgn (
      .haddr (HADDR),
      .hit   (hit[i])
    );
  end

  // isolate the lowest set bit so overlapping regions resolve to the lowest index
  assign HSEL = hit & (~hit + 4'd1);

  assign hro = {HREADYOUT3, HREADYOUT2, HREADYOUT1, HREADYOUT0};
  assign hrs = {HRESP3, HRESP2, HRESP1, HRESP0};

  assign act          = (HTRANS inside {2'b10, 2'b11});
  assign unmapped_act = (HSEL == '0) && act;

  always_comb begin
    ds_d    = ds_q;
    ds_rdy  = 1'b1;
    ds_resp = 1'b0;
    unique case (ds_q)
      DS_IDLE: if (HREADY && unmapped_act) ds_d = DS_ERR1;
      DS_ERR1: begin
        ds_rdy  = 1'b0;
        ds_resp = 1'b1;
        ds_d    = DS_ERR2;
      end
      DS_ERR2: begin
        ds_resp = 1'b1;
        ds_d    = unmapped_act ? DS_ERR1 : DS_IDLE;
      end
      default: ds_d = DS_IDLE;
    endcase
  end

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    if (|sel_d_q) begin
      for (int i = NUM_SLV-1; i >= 0; i--) begin
        if (sel_d_q[i]) begin
          HREADY = hro[i];
          HRESP  = hrs[i];
        end
      end
    end else if (def_d_q) begin
      HREADY = ds_rdy;
      HRESP  = ds_resp;
    end
  end

  always_comb begin
    sel_d_d = sel_d_q;
    def_d_d = def_d_q;
    if (HREADY) begin
      sel_d_d = HSEL;
      def_d_d = unmapped_act;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sel_d_q <= '0;
      def_d_q <= 1'b0;
      ds_q    <= DS_IDLE;
    end else begin
      sel_d_q <= sel_d_d;
      def_d_q <= def_d_d;
      ds_q    <= ds_d;
    end
  end

  assign HSEL_D = sel_d_q;
endmodule

// File: tb/tb_ahb_decoder.sv
// Directed bench for ahb_decoder: decode, data-phase lag, wait states,
// default-slave error sequencing, overlap priority and async reset.

module tb_ahb_decoder;
  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [3:0]  hro, hrs;
  logic [3:0]  HSEL, HSEL_D, o_hsel, o_hsel_d;
  logic        HREADY, HRESP, o_hready, o_hresp;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 HCLK = ~HCLK;

  ahb_decoder u_dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HREADYOUT0(hro[0]), .HREADYOUT1(hro[1]), .HREADYOUT2(hro[2]), .HREADYOUT3(hro[3]),
    .HRESP0(hrs[0]), .HRESP1(hrs[1]), .HRESP2(hrs[2]), .HRESP3(hrs[3]),
    .HSEL(HSEL), .HSEL_D(HSEL_D), .HREADY(HREADY), .HRESP(HRESP)
  );

  // region 3 aliased onto region 2 to exercise the lowest-index priority
  ahb_decoder #(.BASE3(32'h4000_0000), .MASK3(32'hFFFF_F000)) u_ovl (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HREADYOUT0(hro[0]), .HREADYOUT1(hro[1]), .HREADYOUT2(hro[2]), .HREADYOUT3(hro[3]),
    .HRESP0(hrs[0]), .HRESP1(hrs[1]), .HRESP2(hrs[2]), .HRESP3(hrs[3]),
    .HSEL(o_hsel), .HSEL_D(o_hsel_d), .HREADY(o_hready), .HRESP(o_hresp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // step past the next rising edge; inputs are driven and outputs checked mid-cycle
  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic rdy, input logic rsp);
    #2;
    chk({tag, "_rdy"}, 32'(HREADY), 32'(rdy));
    chk({tag, "_rsp"}, 32'(HRESP), 32'(rsp));
  endtask

  initial begin
    HRESET = 1'b1;
    HADDR  = 32'h2000_0010;
    HTRANS = 2'b00;
    hro    = 4'hF;
    hrs    = 4'h0;
    #3;
    chk("rst_hsel", 32'(HSEL), 32'h2);
    chk("rst_hsel_d", 32'(HSEL_D), 32'h0);
    chk("rst_hready", 32'(HREADY), 32'h1);
    chk("rst_hresp", 32'(HRESP), 32'h0);
    #10 HRESET = 1'b0;

    // idle after reset: select still tracks the address, but no error/wait
    cyc();
    chk_rsp("idle", 1'b1, 1'b0);
    chk("idle_hsel_d", 32'(HSEL_D), 32'h2);

    // boundary decode
    HADDR = 32'h0000_FFFF; #1 chk("dec_rom_top", 32'(HSEL), 32'h1);
    HADDR = 32'h0001_0000; #1 chk("dec_rom_past", 32'(HSEL), 32'h0);
    HADDR = 32'h4000_1FFC; #1 chk("dec_tmr_top", 32'(HSEL), 32'h8);
    chk("ovl_tmr_none", 32'(o_hsel), 32'h0);
    HADDR = 32'h4000_0000; #1 chk("ovl_low_idx", 32'(o_hsel), 32'h4);
    chk("dec_gpio", 32'(HSEL), 32'h4);

    // back-to-back zero-wait
    cyc();
    HADDR = 32'h0000_0004; HTRANS = 2'b10;
    cyc();
    HADDR = 32'h2000_0000; HTRANS = 2'b11;
    chk("b2b_d0", 32'(HSEL_D), 32'h1);
    chk_rsp("b2b0", 1'b1, 1'b0);
    cyc();
    HADDR = 32'h4000_1008; HTRANS = 2'b10;
    chk("b2b_d1", 32'(HSEL_D), 32'h2);
    chk_rsp("b2b1", 1'b1, 1'b0);
    cyc();
    HADDR = 32'h4000_0000;
    chk("b2b_d3", 32'(HSEL_D), 32'h8);
    chk_rsp("b2b3", 1'b1, 1'b0);

    // slave 2 inserts three wait states
    cyc();
    HADDR = 32'h0000_0000; hro[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_rsp("ws", 1'b0, 1'b0);
      chk("ws_hold", 32'(HSEL_D), 32'h4);
      cyc();
    end
    hro[2] = 1'b1;
    chk_rsp("ws_end", 1'b1, 1'b0);
    chk("ws_end_sel", 32'(HSEL_D), 32'h4);
    cyc();
    chk("ws_next", 32'(HSEL_D), 32'h1);

    // mapped slave reporting ERROR passes straight through
    hrs[0] = 1'b1;
    chk_rsp("slv_err", 1'b1, 1'b1);
    hrs[0] = 1'b0;

    // unmapped NONSEQ -> ERR1, ERR2, then OKAY
    HADDR = 32'h8000_0000; HTRANS = 2'b10;
    cyc();
    HTRANS = 2'b00;
    chk_rsp("err1", 1'b0, 1'b1);
    chk("err_hsel_d", 32'(HSEL_D), 32'h0);
    cyc();
    chk_rsp("err2", 1'b1, 1'b1);
    cyc();
    chk_rsp("err_done", 1'b1, 1'b0);
    cyc();
    chk_rsp("unm_idle", 1'b1, 1'b0);

    // mapped transfer presented during ERR2
    HTRANS = 2'b10;
    cyc();
    chk_rsp("em_err1", 1'b0, 1'b1);
    cyc();
    HADDR = 32'h2000_0000;
    chk_rsp("em_err2", 1'b1, 1'b1);
    cyc();
    chk("em_sel", 32'(HSEL_D), 32'h2);
    chk_rsp("em_ok", 1'b1, 1'b0);

    // two back-to-back unmapped transfers
    HADDR = 32'h8000_0000;
    cyc();
    chk_rsp("ee_err1a", 1'b0, 1'b1);
    cyc();
    chk_rsp("ee_err2a", 1'b1, 1'b1);
    cyc();
    HTRANS = 2'b00;
    chk_rsp("ee_err1b", 1'b0, 1'b1);
    cyc();
    chk_rsp("ee_err2b", 1'b1, 1'b1);
    cyc();
    chk_rsp("ee_ok", 1'b1, 1'b0);

    // reset during ERR1 clears immediately
    HTRANS = 2'b10;
    cyc();
    chk_rsp("re_err1", 1'b0, 1'b1);
    HRESET = 1'b1;
    #1;
    chk("re_hready", 32'(HREADY), 32'h1);
    chk("re_hresp", 32'(HRESP), 32'h0);
    chk("re_hsel_d", 32'(HSEL_D), 32'h0);
    HTRANS = 2'b00;
    cyc();
    HRESET = 1'b0;
    cyc();
    chk_rsp("re_after", 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
